// File: rtl/ntt_uart_loader.sv
// UART byte-stream front-end for the NTT core: parses framed commands, preloads stage twiddle RAMs, streams data.
// Optional feature: define LOADER_MOD_CHECK_EN to reject any assembled word >= MODULUS.
module ntt_uart_loader #(
  parameter int          W          = 32,
  parameter int          RADIX      = 16,
  parameter int          NUM_STAGES = $clog2(RADIX),
  parameter int          ADDR_W     = $clog2(RADIX / 2),
  parameter logic [31:0] MODULUS    = 32'd7681
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_valid_i,
  input  logic [7:0]            uart_byte_i,
  output logic [NUM_STAGES-1:0] tw_we_o,
  output logic [ADDR_W-1:0]     tw_addr_o,
  output logic [W-1:0]          tw_data_o,
  output logic                  start_o,
  output logic                  data_valid_o,
  output logic [W-1:0]          data_o,
  input  logic                  ntt_done_i,
  output logic                  busy_o,
  output logic                  tw_loaded_o,
  output logic                  err_o
);

  localparam int BYTES    = W / 8;
  localparam int BCNT_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IDX_W    = $clog2(RADIX);
  localparam int TW_WORDS = RADIX / 2;
  localparam int SW       = $clog2(NUM_STAGES);
  localparam logic [W-1:0] MOD_W = W'(MODULUS);
`ifdef LOADER_MOD_CHECK_EN
  localparam bit MOD_CHECK = 1'b1;
`else
  localparam bit MOD_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RX_TW, PRELOAD, RX_DATA, STREAM, WAIT_DONE} state_e;

  state_e                state_q, state_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [W-1:0]          asm_q, asm_d;
  logic [IDX_W-1:0]      widx_q, widx_d;
  logic [SW-1:0]         stg_q, stg_d;
  logic [ADDR_W-1:0]     j_q, j_d;
  logic [NUM_STAGES-1:0] tw_we_q, tw_we_d;
  logic [ADDR_W-1:0]     tw_addr_q, tw_addr_d;
  logic [W-1:0]          tw_data_q, tw_data_d;
  logic                  start_q, start_d;
  logic                  dv_q, dv_d;
  logic [W-1:0]          data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  loaded_q, loaded_d;
  logic                  err_q, err_d;

  logic [W-1:0]          twbuf [TW_WORDS];
  logic [W-1:0]          dbuf  [RADIX];
  logic                  tw_buf_we, d_buf_we, mod_bad, word_last;
  logic [W-1:0]          word_full;

  // Bytes arrive little-endian, so each new byte enters at the top and shifts toward bit 0.
  assign word_full = (asm_q >> 8) | (W'(uart_byte_i) << (W - 8));
  assign mod_bad   = MOD_CHECK && (word_full >= MOD_W);
  assign word_last = (state_q == RX_TW) ? (widx_q == IDX_W'(TW_WORDS - 1))
                                        : (widx_q == IDX_W'(RADIX - 1));

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
    widx_d    = widx_q;
    stg_d     = stg_q;
    j_d       = j_q;
    tw_we_d   = '0;
    tw_addr_d = '0;
    tw_data_d = '0;
    start_d   = 1'b0;
    dv_d      = 1'b0;
    data_d    = '0;
    loaded_d  = loaded_q;
    err_d     = 1'b0;
    tw_buf_we = 1'b0;
    d_buf_we  = 1'b0;
    // The final stage holds a single entry, so its write is always the last of the preload.
    if (tw_we_q[NUM_STAGES-1]) loaded_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (uart_valid_i) begin
          if (uart_byte_i == 8'hA5) begin
            state_d  = RX_TW;
            loaded_d = 1'b0;
          end else if (uart_byte_i == 8'h5A) begin
            if (loaded_q) state_d = RX_DATA;
            else          err_d   = 1'b1;
          end
        end
      end
      RX_TW, RX_DATA: begin
        if (uart_valid_i) begin
          asm_d  = word_full;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BCNT_W'(BYTES - 1)) begin
            bcnt_d = '0;
            if (mod_bad) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              tw_buf_we = (state_q == RX_TW);
              d_buf_we  = (state_q == RX_DATA);
              widx_d    = widx_q + 1'b1;
              if (word_last) state_d = (state_q == RX_TW) ? PRELOAD : STREAM;
            end
          end
        end
      end
      PRELOAD: begin
        tw_we_d   = NUM_STAGES'(1) << stg_q;
        tw_addr_d = j_q;
        tw_data_d = twbuf[ADDR_W'(j_q << stg_q)];
        if (j_q == (ADDR_W'(TW_WORDS - 1) >> stg_q)) begin
          j_d   = '0;
          stg_d = stg_q + 1'b1;
          if (stg_q == SW'(NUM_STAGES - 1)) state_d = IDLE;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      STREAM: begin
        dv_d    = 1'b1;
        data_d  = dbuf[widx_q];
        start_d = (widx_q == '0);
        widx_d  = widx_q + 1'b1;
        if (widx_q == IDX_W'(RADIX - 1)) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (ntt_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Every state entry starts with a clean byte counter, word assembly and indices.
    if (state_d != state_q) begin
      bcnt_d = '0;
      asm_d  = '0;
      widx_d = '0;
      stg_d  = '0;
      j_d    = '0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      asm_q     <= '0;
      widx_q    <= '0;
      stg_q     <= '0;
      j_q       <= '0;
      tw_we_q   <= '0;
      tw_addr_q <= '0;
      tw_data_q <= '0;
      start_q   <= 1'b0;
      dv_q      <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      loaded_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      asm_q     <= asm_d;
      widx_q    <= widx_d;
      stg_q     <= stg_d;
      j_q       <= j_d;
      tw_we_q   <= tw_we_d;
      tw_addr_q <= tw_addr_d;
      tw_data_q <= tw_data_d;
      start_q   <= start_d;
      dv_q      <= dv_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      loaded_q  <= loaded_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tw_buf_we) twbuf[widx_q[ADDR_W-1:0]] <= word_full;
    if (d_buf_we)  dbuf[widx_q]              <= word_full;
  end

  assign tw_we_o      = tw_we_q;
  assign tw_addr_o    = tw_addr_q;
  assign tw_data_o    = tw_data_q;
  assign start_o      = start_q;
  assign data_valid_o = dv_q;
  assign data_o       = data_q;
  assign busy_o       = busy_q;
  assign tw_loaded_o  = loaded_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_ntt_uart_loader.sv
// Self-checking bench for ntt_uart_loader (W=32, RADIX=16) against a queue/array reference model.
module tb_ntt_uart_loader;
  localparam int W = 32, RADIX = 16, NS = 4, AW = 3, TWN = 8, BYTES = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_valid_i = 1'b0;
  logic [7:0]    uart_byte_i = 8'h00;
  logic          ntt_done_i = 1'b0;
  logic [NS-1:0] tw_we_o;
  logic [AW-1:0] tw_addr_o;
  logic [W-1:0]  tw_data_o;
  logic          start_o, data_valid_o, busy_o, tw_loaded_o, err_o;
  logic [W-1:0]  data_o;

  ntt_uart_loader dut (
    .clk(clk), .rst(rst), .uart_valid_i(uart_valid_i), .uart_byte_i(uart_byte_i),
    .tw_we_o(tw_we_o), .tw_addr_o(tw_addr_o), .tw_data_o(tw_data_o),
    .start_o(start_o), .data_valid_o(data_valid_o), .data_o(data_o),
    .ntt_done_i(ntt_done_i), .busy_o(busy_o), .tw_loaded_o(tw_loaded_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;

  typedef struct { int stage; int addr; logic [W-1:0] data; int cyc; } twr_t;
  typedef struct { logic [W-1:0] data; logic start; int cyc; } str_t;
  twr_t         twq[$];
  str_t         strq[$];
  int           cyc = 0, errCnt = 0, strayStart = 0, loadedRiseCyc = -1;
  logic         loadedPrev = 1'b0;
  logic [W-1:0] ramObs [NS][TWN];
  logic [W-1:0] twModel [TWN];
  logic [W-1:0] dModel [RADIX];

  // Observed activity is logged on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    for (int s = 0; s < NS; s++)
      if (tw_we_o[s]) begin
        twq.push_back('{s, int'(tw_addr_o), tw_data_o, cyc});
        ramObs[s][tw_addr_o] = tw_data_o;
      end
    if (data_valid_o) strq.push_back('{data_o, start_o, cyc});
    if (start_o && !data_valid_o) strayStart++;
    if (err_o) errCnt++;
    if (tw_loaded_o && !loadedPrev) loadedRiseCyc = cyc;
    loadedPrev = tw_loaded_o;
  end

  function automatic logic [W-1:0] rand_word();
`ifdef LOADER_MOD_CHECK_EN
    return W'($urandom_range(0, 7680));
`else
    return W'($urandom);
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    uart_valid_i = 1'b1;
    uart_byte_i  = b;
    @(posedge clk); #1;
    uart_valid_i = 1'b0;
    uart_byte_i  = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int b = 0; b < BYTES; b++) send_byte(w[8*b +: 8]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tw_we_o !== '0) $display("[TB] FAIL reset_tw_we got %0h want 0", tw_we_o); else passed++;
    checks++; if (tw_addr_o !== '0) $display("[TB] FAIL reset_tw_addr got %0h want 0", tw_addr_o); else passed++;
    checks++; if (tw_data_o !== '0) $display("[TB] FAIL reset_tw_data got %0h want 0", tw_data_o); else passed++;
    checks++; if ({start_o, data_valid_o} !== 2'b00) $display("[TB] FAIL reset_start_valid got %b want 00", {start_o, data_valid_o}); else passed++;
    checks++; if (data_o !== '0) $display("[TB] FAIL reset_data got %0h want 0", data_o); else passed++;
    checks++; if ({busy_o, tw_loaded_o, err_o} !== 3'b000) $display("[TB] FAIL reset_flags got %b want 000", {busy_o, tw_loaded_o, err_o}); else passed++;
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL post_reset_busy got %b want 0", busy_o); else passed++;
  endtask

  task automatic test_data_before_tw();
    int e0 = errCnt;
    strq.delete();
    send_byte(8'h5A);
    repeat (4) @(negedge clk);
    checks++; if (errCnt - e0 !== 1) $display("[TB] FAIL nodata_err_pulses got %0d want 1", errCnt - e0); else passed++;
    checks++; if (strq.size() !== 0) $display("[TB] FAIL nodata_stream got %0d words want 0", strq.size()); else passed++;
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL nodata_busy got %b want 0", busy_o); else passed++;
  endtask

  task automatic test_twiddle_load(input string tag);
    int t = 0, n = 0;
    twq.delete();
    loadedRiseCyc = -1;
    send_byte(8'hA5);
    for (int k = 0; k < TWN; k++) send_word(twModel[k]);
    while (!tw_loaded_o && t < 300) begin @(negedge clk); t++; end
    checks++; if (tw_loaded_o !== 1'b1) $display("[TB] FAIL %s_loaded got %b want 1", tag, tw_loaded_o); else passed++;
    repeat (2) @(negedge clk);
    checks++; if (twq.size() !== RADIX - 1) $display("[TB] FAIL %s_write_count got %0d want %0d", tag, twq.size(), RADIX - 1); else passed++;
    // Expected write order: stage-major, address ascending; entry j of stage s is tw[j*2^s].
    for (int s = 0; s < NS; s++)
      for (int j = 0; j < (TWN >> s); j++) begin
        if (n < twq.size()) begin
          checks++;
          if (twq[n].stage !== s || twq[n].addr !== j || twq[n].data !== twModel[j * (2 ** s)])
            $display("[TB] FAIL %s_write%0d got s%0d a%0d %0h want s%0d a%0d %0h", tag, n,
                     twq[n].stage, twq[n].addr, twq[n].data, s, j, twModel[j * (2 ** s)]);
          else passed++;
        end
        n++;
      end
    if (twq.size() > 0) begin
      checks++;
      if (twq[twq.size()-1].cyc - twq[0].cyc !== RADIX - 2)
        $display("[TB] FAIL %s_write_span got %0d want %0d", tag, twq[twq.size()-1].cyc - twq[0].cyc, RADIX - 2);
      else passed++;
      checks++;
      if (loadedRiseCyc !== twq[twq.size()-1].cyc + 1)
        $display("[TB] FAIL %s_loaded_timing got %0d want %0d", tag, loadedRiseCyc, twq[twq.size()-1].cyc + 1);
      else passed++;
    end
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL %s_busy_after got %b want 0", tag, busy_o); else passed++;
  endtask

  task automatic test_stream(input string tag, input bit holdDone);
    int t = 0, bad = 0;
    logic [RADIX-1:0] starts = '0;
    strq.delete();
    twq.delete();
    ntt_done_i = holdDone;
    send_byte(8'h5A);
    for (int i = 0; i < RADIX; i++) send_word(dModel[i]);
    ntt_done_i = 1'b0;
    while (strq.size() < RADIX && t < 300) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    checks++; if (strq.size() !== RADIX) $display("[TB] FAIL %s_stream_len got %0d want %0d", tag, strq.size(), RADIX); else passed++;
    for (int i = 0; i < RADIX && i < strq.size(); i++) begin
      starts[i] = strq[i].start;
      checks++;
      if (strq[i].data !== dModel[i]) $display("[TB] FAIL %s_data%0d got %0h want %0h", tag, i, strq[i].data, dModel[i]);
      else passed++;
    end
    checks++; if (starts !== RADIX'(1)) $display("[TB] FAIL %s_start_pattern got %b want %b", tag, starts, RADIX'(1)); else passed++;
    if (strq.size() > 0) begin
      checks++;
      if (strq[strq.size()-1].cyc - strq[0].cyc !== RADIX - 1)
        $display("[TB] FAIL %s_stream_span got %0d want %0d", tag, strq[strq.size()-1].cyc - strq[0].cyc, RADIX - 1);
      else passed++;
    end
    checks++; if (strayStart !== 0) $display("[TB] FAIL %s_stray_start got %0d want 0", tag, strayStart); else passed++;
    checks++; if (busy_o !== 1'b1) $display("[TB] FAIL %s_busy_wait got %b want 1", tag, busy_o); else passed++;
    send_byte(8'h5A);
    send_byte(8'hA5);
    @(negedge clk);
    checks++; if (busy_o !== 1'b1) $display("[TB] FAIL %s_busy_hold got %b want 1", tag, busy_o); else passed++;
    @(posedge clk); #1; ntt_done_i = 1'b1;
    @(posedge clk); #1; ntt_done_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL %s_busy_done got %b want 0", tag, busy_o); else passed++;
    checks++; if (twq.size() !== 0) $display("[TB] FAIL %s_tw_writes got %0d want 0", tag, twq.size()); else passed++;
    for (int s = 0; s < NS; s++)
      for (int j = 0; j < (TWN >> s); j++)
        if (ramObs[s][j] !== twModel[j * (2 ** s)]) bad++;
    checks++; if (bad !== 0) $display("[TB] FAIL %s_table_kept got %0d bad entries want 0", tag, bad); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < RADIX; i++) dModel[i] = rand_word();
      test_stream($sformatf("b2b%0d", f), f == 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5);
    for (int b = 0; b < 4; b++) send_byte(8'($urandom));
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({tw_loaded_o, busy_o} !== 2'b00) $display("[TB] FAIL midrst_flags got %b want 00", {tw_loaded_o, busy_o}); else passed++;
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < TWN; k++) twModel[k] = rand_word();
    test_twiddle_load("midrst");
  endtask

`ifdef LOADER_MOD_CHECK_EN
  task automatic test_mod_check();
    int e0 = errCnt;
    twq.delete();
    send_byte(8'hA5);
    send_word(32'd7681);
    repeat (4) @(negedge clk);
    checks++; if (errCnt - e0 !== 1) $display("[TB] FAIL modchk_err got %0d want 1", errCnt - e0); else passed++;
    checks++; if (twq.size() !== 0) $display("[TB] FAIL modchk_writes got %0d want 0", twq.size()); else passed++;
    checks++; if ({tw_loaded_o, busy_o} !== 2'b00) $display("[TB] FAIL modchk_flags got %b want 00", {tw_loaded_o, busy_o}); else passed++;
    for (int k = 0; k < TWN; k++) twModel[k] = rand_word();
    twModel[0] = 32'd7680;
    test_twiddle_load("modok");
  endtask
`endif

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_data_before_tw();
    for (int k = 0; k < TWN; k++) twModel[k] = W'(k + 1);
    test_twiddle_load("fixed");
    for (int i = 0; i < RADIX; i++) dModel[i] = W'(32'h100 + i);
    test_stream("fixed", 1'b0);
    test_back_to_back();
    test_reset_mid_frame();
`ifdef LOADER_MOD_CHECK_EN
    test_mod_check();
`endif
    for (int i = 0; i < RADIX; i++) dModel[i] = rand_word();
    test_stream("final", 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
